sum_accumulator: RTL and testbench

//  Downstream consumer of the registered adder_top result (sum + overflow). Collects a

---
 rtl/sum_accumulator.sv | 108 ++++++++++
 tb/tb_sum_accumulator.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sum_accumulator.sv
// sum_accumulator: collects a frame of adder results over a valid/ready handshake
// and reports the exact frame total plus the number of beats that carried overflow.
module sum_accumulator #(
    parameter int unsigned WIDTH   = 25,
    parameter int unsigned COUNT_W = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [COUNT_W-1:0]           frame_len,
    input  logic                         abort,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_sum,
    input  logic                         in_overflow,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH+1+COUNT_W-1:0]   out_acc,
    output logic [COUNT_W-1:0]           out_ovf_cnt,
    output logic                         busy
);

    // Accumulator is wide enough for a maximum-length frame of maximum beats.
    localparam int unsigned ACC_W = WIDTH + 1 + COUNT_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [COUNT_W-1:0]   rem_q, rem_d;
    logic [COUNT_W-1:0]   ovf_q, ovf_d;

    logic [ACC_W-1:0]     beat;
    logic [COUNT_W-1:0]   ovf_inc;

    assign beat    = {{(ACC_W-WIDTH-1){1'b0}}, in_overflow, in_sum};
    assign ovf_inc = {{(COUNT_W-1){1'b0}}, in_overflow};

    // Outputs are decoded from state or taken straight from registers.
    assign in_ready    = (state_q == ACCUM);
    assign out_valid   = (state_q == DONE);
    assign busy        = (state_q != IDLE);
    assign out_acc     = acc_q;
    assign out_ovf_cnt = ovf_q;

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            rem_q   <= '0;
            ovf_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state and datapath update; abort overrides every other transition.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        ovf_d   = ovf_q;
        if (abort) begin
            state_d = IDLE;
            acc_d   = '0;
            rem_d   = '0;
            ovf_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        acc_d   = '0;
                        ovf_d   = '0;
                        rem_d   = frame_len;
                        state_d = (frame_len == '0) ? DONE : ACCUM;
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        acc_d = acc_q + beat;
                        ovf_d = ovf_q + ovf_inc;
                        rem_d = rem_q - COUNT_W'(1);
                        if (rem_q == COUNT_W'(1)) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sum_accumulator.sv
// Scoreboard bench for sum_accumulator: stimulus pushes expected frame results,
// a monitor pops and compares on each new out_valid assertion.
module tb_sum_accumulator;

    localparam int unsigned WIDTH   = 25;
    localparam int unsigned COUNT_W = 8;
    localparam int unsigned ACC_W   = WIDTH + 1 + COUNT_W;

    typedef struct packed {
        logic [ACC_W-1:0]   acc;
        logic [COUNT_W-1:0] ovf;
    } exp_t;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic [COUNT_W-1:0] frame_len;
    logic               abort;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_sum;
    logic               in_overflow;
    logic               out_valid;
    logic               out_ready;
    logic [ACC_W-1:0]   out_acc;
    logic [COUNT_W-1:0] out_ovf_cnt;
    logic               busy;

    int   total = 0;
    int   bad   = 0;
    exp_t sb_q[$];

    sum_accumulator #(
        .WIDTH   (WIDTH),
        .COUNT_W (COUNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .frame_len   (frame_len),
        .abort       (abort),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_sum      (in_sum),
        .in_overflow (in_overflow),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_acc     (out_acc),
        .out_ovf_cnt (out_ovf_cnt),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare each result the first cycle out_valid is seen high.
    initial begin
        logic prev_valid;
        exp_t e;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_valid = 1'b0;
            end else begin
                if (out_valid && !prev_valid) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_result", 64'(out_valid), 64'(0));
                    end else begin
                        e = sb_q.pop_front();
                        check("sb_acc", 64'(out_acc), 64'(e.acc));
                        check("sb_ovf_cnt", 64'(out_ovf_cnt), 64'(e.ovf));
                    end
                end
                prev_valid = out_valid;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [ACC_W-1:0] acc, input logic [COUNT_W-1:0] ovf);
        exp_t e;
        e.acc = acc;
        e.ovf = ovf;
        sb_q.push_back(e);
    endtask

    task automatic start_frame(input logic [COUNT_W-1:0] len);
        start     = 1'b1;
        frame_len = len;
        tick();
        start     = 1'b0;
        frame_len = '0;
    endtask

    // Present one beat and hold it until it is accepted (bounded).
    task automatic send_beat(input logic [WIDTH-1:0] s, input logic o, input int unsigned gap);
        logic acc_now;
        logic done;
        for (int unsigned g = 0; g < gap; g++) tick();
        in_valid    = 1'b1;
        in_sum      = s;
        in_overflow = o;
        done        = 1'b0;
        for (int n = 0; n < 50 && !done; n++) begin
            acc_now = in_ready;
            tick();
            done = acc_now;
        end
        if (!done) check("beat_accept_timeout", 64'(0), 64'(1));
        in_valid    = 1'b0;
        in_sum      = '0;
        in_overflow = 1'b0;
    endtask

    task automatic wait_valid();
        logic seen;
        seen = 1'b0;
        for (int n = 0; n < 50 && !seen; n++) begin
            if (out_valid) seen = 1'b1;
            else tick();
        end
        if (!seen) check("out_valid_timeout", 64'(0), 64'(1));
    endtask

    task automatic finish_frame(input int unsigned hold);
        wait_valid();
        for (int unsigned h = 0; h < hold; h++) tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("post_handshake_valid", 64'(out_valid), 64'(0));
        check("post_handshake_busy", 64'(busy), 64'(0));
    endtask

    initial begin
        rst_n       = 1'b0;
        start       = 1'b0;
        frame_len   = '0;
        abort       = 1'b0;
        in_valid    = 1'b0;
        in_sum      = '0;
        in_overflow = 1'b0;
        out_ready   = 1'b0;

        // Reset state
        #12;
        check("rst_in_ready", 64'(in_ready), 64'(0));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_acc", 64'(out_acc), 64'(0));
        check("rst_ovf_cnt", 64'(out_ovf_cnt), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        rst_n = 1'b1;
        tick();

        // 1: 5 + 0x1FFFFFF+2^25 + 10 = 0x400000E, one overflow beat
        push_exp(34'h400000E, 8'd1);
        start_frame(8'd3);
        check("t1_busy", 64'(busy), 64'(1));
        send_beat(25'd5, 1'b0, 0);
        send_beat(25'h1FFFFFF, 1'b1, 0);
        send_beat(25'd10, 1'b0, 0);
        check("t1_latency_valid", 64'(out_valid), 64'(1));
        finish_frame(0);

        // 2: empty frame goes straight to DONE with zero results
        push_exp(34'h0, 8'd0);
        check("t2_idle_in_ready", 64'(in_ready), 64'(0));
        start_frame(8'd0);
        check("t2_done_valid", 64'(out_valid), 64'(1));
        check("t2_done_in_ready", 64'(in_ready), 64'(0));
        finish_frame(1);

        // 3: 255 beats of 0x3FFFFFF = 0x3FBFFFF01 (fits in 34 bits), random gaps
        push_exp(34'h3FBFFFF01, 8'd255);
        start_frame(8'd255);
        for (int i = 0; i < 255; i++) send_beat(25'h1FFFFFF, 1'b1, $urandom_range(0, 2));
        finish_frame(0);

        // 4: 3 + (4 + 2^25) = 0x2000007, held in DONE while start/in_valid toggle
        push_exp(34'h2000007, 8'd1);
        start_frame(8'd2);
        send_beat(25'd3, 1'b0, 0);
        send_beat(25'd4, 1'b1, 0);
        for (int i = 0; i < 10; i++) begin
            start     = i[0];
            in_valid  = ~i[0];
            frame_len = 8'd5;
            in_sum    = 25'd99;
            tick();
            check("t4_hold_valid", 64'(out_valid), 64'(1));
            check("t4_hold_acc", 64'(out_acc), 64'(34'h2000007));
            check("t4_hold_ovf", 64'(out_ovf_cnt), 64'(1));
            check("t4_hold_in_ready", 64'(in_ready), 64'(0));
        end
        start     = 1'b0;
        in_valid  = 1'b0;
        frame_len = '0;
        in_sum    = '0;
        finish_frame(0);

        // 5: abort after 2 of 4 beats (beat offered with abort is dropped)
        start_frame(8'd4);
        send_beat(25'd100, 1'b0, 0);
        send_beat(25'd200, 1'b1, 0);
        abort       = 1'b1;
        in_valid    = 1'b1;
        in_sum      = 25'd300;
        tick();
        abort       = 1'b0;
        in_valid    = 1'b0;
        in_sum      = '0;
        check("t5_abort_busy", 64'(busy), 64'(0));
        check("t5_abort_valid", 64'(out_valid), 64'(0));
        check("t5_abort_acc", 64'(out_acc), 64'(0));
        check("t5_abort_ovf", 64'(out_ovf_cnt), 64'(0));
        push_exp(34'd7, 8'd0);
        start_frame(8'd1);
        send_beat(25'd7, 1'b0, 0);
        finish_frame(0);

        // 6: asynchronous reset between edges mid-frame
        start_frame(8'd3);
        send_beat(25'd50, 1'b1, 0);
        #3;
        rst_n = 1'b0;
        #1;
        check("t6_rst_in_ready", 64'(in_ready), 64'(0));
        check("t6_rst_busy", 64'(busy), 64'(0));
        check("t6_rst_acc", 64'(out_acc), 64'(0));
        check("t6_rst_ovf", 64'(out_ovf_cnt), 64'(0));
        #12;
        rst_n = 1'b1;
        tick();
        check("t6_after_busy", 64'(busy), 64'(0));
        push_exp(34'd3, 8'd0);
        start_frame(8'd2);
        send_beat(25'd1, 1'b0, 0);
        send_beat(25'd2, 1'b0, 0);
        finish_frame(0);

        tick();
        tick();
        check("sb_drained", 64'(sb_q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
